// File: rtl/serial_tx_framer_if.sv
// Load/serial-line bundle for serial_tx_framer: the source drives the payload
// handshake, the framer drives load_ready and the flop-driven line outputs.
interface serial_tx_framer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             d_out;
   logic             busy;
   logic             done;

   modport master (
      output data_in, load_valid,
      input  load_ready, d_out, busy, done
   );

   modport slave (
      input  data_in, load_valid,
      output load_ready, d_out, busy, done
   );
endinterface

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial frame transmitter: start(0), WIDTH data bits LSB-first,
// optional even parity (define SERIAL_TX_PARITY_EN), stop(1); BAUD_DIV clocks per bit.
module serial_tx_framer #(
   parameter int WIDTH    = 8,
   parameter int BAUD_DIV = 4
) (
   input  logic               clock,
   input  logic               reset,
   serial_tx_framer_if.slave  bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [7:0] BAUD_LAST = 8'(BAUD_DIV - 1);
   localparam logic [5:0] LAST_BIT  = 6'(WIDTH - 1);

   logic [2:0]       r_state;
   logic [WIDTH-1:0] r_shift;
   logic [7:0]       r_baud_cnt;
   logic [5:0]       r_bit_cnt;
   logic             r_dout;
   logic             r_busy;
   logic             r_done;
`ifdef SERIAL_TX_PARITY_EN
   logic             r_parity;
`endif
   logic             w_bit_end;

   assign w_bit_end      = (r_baud_cnt == 8'd0);
   assign bus.load_ready = (r_state == IDLE) && !reset;
   assign bus.d_out      = r_dout;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_dout     <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.load_valid) begin
                  r_shift    <= bus.data_in;
`ifdef SERIAL_TX_PARITY_EN
                  r_parity   <= ^bus.data_in;
`endif
                  r_state    <= START;
                  r_dout     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_baud_cnt <= BAUD_LAST;
                  r_bit_cnt  <= '0;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_state    <= DATA;
                  r_dout     <= r_shift[0];
                  r_shift    <= r_shift >> 1;
                  r_baud_cnt <= BAUD_LAST;
               end else begin
                  r_baud_cnt <= r_baud_cnt - 8'd1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= BAUD_LAST;
                  if (r_bit_cnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                     r_state <= PARITY;
                     r_dout  <= r_parity;
`else
                     r_state <= STOP;
                     r_dout  <= 1'b1;
                     r_done  <= (BAUD_DIV == 1);
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                     r_dout    <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 8'd1;
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               if (w_bit_end) begin
                  r_state    <= STOP;
                  r_dout     <= 1'b1;
                  r_done     <= (BAUD_DIV == 1);
                  r_baud_cnt <= BAUD_LAST;
               end else begin
                  r_baud_cnt <= r_baud_cnt - 8'd1;
               end
            end
`endif
            STOP: begin
               // done is registered, so it is raised one edge ahead of the last stop cycle
               if (w_bit_end) begin
                  r_state <= IDLE;
                  r_dout  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_baud_cnt <= r_baud_cnt - 8'd1;
                  r_done     <= (r_baud_cnt == 8'd1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_dout  <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer: one instance at BAUD_DIV=4, one at BAUD_DIV=1,
// plus a negative-edge flop model on the serial line.
module tb_serial_tx_framer;

   localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   serial_tx_framer_if #(.WIDTH(W)) if_a ();
   serial_tx_framer_if #(.WIDTH(W)) if_b ();

   serial_tx_framer #(.WIDTH(W), .BAUD_DIV(4)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (if_a)
   );

   serial_tx_framer #(.WIDTH(W), .BAUD_DIV(1)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (if_b)
   );

   // downstream negative-edge D flip-flop fed by the serial line
   logic q_neg = 1'b1;
   always @(negedge clock) q_neg <= if_a.d_out;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] p, input int k, input int bd);
      int idx;
      idx = (k - 1) / bd;
      if (idx == 0) return 1'b0;
      if (idx <= W) return p[idx-1];
      if (P == 1 && idx == W + 1) return ^p;
      return 1'b1;
   endfunction

   task automatic run_frame_a(input logic [7:0] payload, input bit busy_offer);
      int fl;
      fl = (2 + W + P) * 4;
      @(negedge clock);
      check("ready_pre", if_a.load_ready, 1);
      if_a.data_in    = payload;
      if_a.load_valid = 1'b1;
      for (int k = 1; k <= fl; k++) begin
         @(negedge clock);
         check($sformatf("dout_%0h_c%0d", payload, k), if_a.d_out, exp_bit(payload, k, 4));
         check($sformatf("busy_c%0d", k), if_a.busy, 1);
         check($sformatf("done_c%0d", k), if_a.done, (k == fl));
         check($sformatf("ready_c%0d", k), if_a.load_ready, 0);
         #1;
         check($sformatf("qneg_c%0d", k), q_neg, exp_bit(payload, k, 4));
         if (busy_offer) begin
            if_a.data_in = (k == 1) ? 8'h3C : 8'($urandom);
            if (k == fl) if_a.load_valid = 1'b0;
         end else begin
            if_a.load_valid = 1'b0;
         end
      end
      @(negedge clock);
      check("idle_busy", if_a.busy, 0);
      check("idle_dout", if_a.d_out, 1);
      check("idle_done", if_a.done, 0);
      check("idle_ready", if_a.load_ready, 1);
      @(negedge clock);
      check("no_requeue_busy", if_a.busy, 0);
   endtask

   initial begin
      bit seen_done;
      bit seen_busy;
      int fb;
      if_a.data_in = '0; if_a.load_valid = 1'b0;
      if_b.data_in = '0; if_b.load_valid = 1'b0;

      // reset state
      @(negedge clock);
      @(negedge clock);
      check("rst_ready", if_a.load_ready, 0);
      check("rst_dout", if_a.d_out, 1);
      check("rst_busy", if_a.busy, 0);
      check("rst_done", if_a.done, 0);
      reset = 1'b0;
      #1;
      check("rst_release_ready", if_a.load_ready, 1);

      run_frame_a(8'hA5, 1'b0);
      run_frame_a(8'h01, 1'b0);
      run_frame_a(8'hA5, 1'b1);

      // reset mid-frame at cycle 13 with a coincident load_valid
      @(negedge clock);
      if_a.data_in = 8'hA5; if_a.load_valid = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         if_a.load_valid = 1'b0;
         check($sformatf("abort_dout_c%0d", k), if_a.d_out, exp_bit(8'hA5, k, 4));
      end
      reset = 1'b1;
      if_a.data_in = 8'h3C; if_a.load_valid = 1'b1;
      #1;
      check("abort_ready_in_rst", if_a.load_ready, 0);
      @(negedge clock);
      check("abort_dout", if_a.d_out, 1);
      check("abort_busy", if_a.busy, 0);
      check("abort_done", if_a.done, 0);
      reset = 1'b0;
      if_a.load_valid = 1'b0;
      #1;
      check("abort_ready_after", if_a.load_ready, 1);
      seen_done = 1'b0; seen_busy = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         seen_done |= if_a.done;
         seen_busy |= if_a.busy;
      end
      check("abort_no_done", seen_done, 0);
      check("abort_no_resume", seen_busy, 0);

      // BAUD_DIV=1 back-to-back frames with load_valid held high
      fb = 2 + W + P;
      @(negedge clock);
      if_b.data_in = 8'hFF; if_b.load_valid = 1'b1;
      for (int k = 1; k <= fb; k++) begin
         @(negedge clock);
         if_b.data_in = 8'h00;
         check($sformatf("b1_dout_c%0d", k), if_b.d_out, exp_bit(8'hFF, k, 1));
         check($sformatf("b1_busy_c%0d", k), if_b.busy, 1);
         check($sformatf("b1_done_c%0d", k), if_b.done, (k == fb));
      end
      @(negedge clock);
      check("b_gap_busy", if_b.busy, 0);
      check("b_gap_ready", if_b.load_ready, 1);
      check("b_gap_dout", if_b.d_out, 1);
      for (int k = 1; k <= fb; k++) begin
         @(negedge clock);
         if_b.load_valid = 1'b0;
         check($sformatf("b2_dout_c%0d", k), if_b.d_out, exp_bit(8'h00, k, 1));
         check($sformatf("b2_busy_c%0d", k), if_b.busy, 1);
         check($sformatf("b2_done_c%0d", k), if_b.done, (k == fb));
      end
      @(negedge clock);
      check("b_end_busy", if_b.busy, 0);
      @(negedge clock);
      check("b_end_idle", if_b.busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_tx_framer.md
SERIAL_TX_FRAMER -- requirements
Module: serial_tx_framer

Interface
REQ-001 Parameter WIDTH, default 8, is the payload bits per frame (legal range 1..32).
REQ-002 Parameter BAUD_DIV, default 4, is the clock cycles per serial bit (legal range 1..255).
REQ-003 clock  input  1  is the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  is the reset; synchronous, active-high.
REQ-005 data_in  input  WIDTH  is the parallel payload to transmit.
REQ-006 load_valid  input  1  means the source offers data_in.
REQ-007 load_ready  output  1  means the framer accepts a payload this cycle.
REQ-008 d_out  output  1  is the serial line feeding the downstream negative-edge D flip-flop (d input); idle-high.
REQ-009 busy  output  1  is high while a frame is in progress.
REQ-010 done  output  1  is a one-cycle pulse at frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY (present only with PARITY_EN) and STOP.
REQ-012 load_ready SHALL equal 1 exactly when the state is IDLE and reset is low.
REQ-013 A payload SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; data_in SHALL be latched into an internal shift register on that edge.
REQ-014 Changes to data_in after acceptance SHALL NOT affect the frame in progress.
REQ-015 load_valid while not in IDLE SHALL be ignored, with no queuing.
REQ-016 The cycle after acceptance, state SHALL be START with d_out=0 and busy=1.
REQ-017 Each bit SHALL be held on d_out for exactly BAUD_DIV cycles, timed by a bit-period counter.
REQ-018 The counter SHALL reload at every bit boundary.
REQ-019 DATA SHALL emit WIDTH bits LSB-first, with a bit counter tracking the bits sent.
REQ-020 After the last data bit the FSM SHALL enter PARITY if compiled in, otherwise STOP.
REQ-021 STOP SHALL drive d_out=1 for BAUD_DIV cycles.
REQ-022 done SHALL be 1 on the final cycle of STOP, and the FSM SHALL then return to IDLE.
REQ-023 A new frame SHALL be accepted no earlier than the first IDLE cycle, so there is a minimum one idle cycle between frames.
REQ-024 Frame length SHALL be (2+WIDTH+P)*BAUD_DIV cycles from the first START cycle, where P=1 with PARITY_EN and P=0 without.
REQ-025 d_out, busy and done SHALL be driven directly from flops, so they change only after rising edges and are stable across the following falling edge used by the downstream stage.
REQ-026 With BAUD_DIV=1, every state SHALL last exactly one cycle with no skipped or repeated bits.
REQ-027 In IDLE, d_out SHALL be 1, busy SHALL be 0 and done SHALL be 0.

Reset
REQ-028 While reset=1 at a rising edge, the next state SHALL be IDLE with d_out=1, busy=0, done=0, and counters and shift register cleared to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame: no done pulse and no partial resume.
REQ-030 load_ready SHALL be 0 during any cycle in which reset=1.
REQ-031 load_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-032 A load_valid coincident with reset SHALL be dropped.

Configuration
REQ-033 Macro SERIAL_TX_PARITY_EN, when defined, SHALL compile in the PARITY state.
REQ-034 With the macro defined, the PARITY state SHALL emit one even-parity bit (XOR of all payload bits) for BAUD_DIV cycles between DATA and STOP.
REQ-035 With the macro undefined, no PARITY state or parity logic SHALL exist, and DATA SHALL go directly to STOP.

Verification
REQ-036 Parity off, WIDTH=8, BAUD_DIV=4, load 0xA5 -> d_out 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; done pulses on cycle 40; busy high for 40 cycles.
REQ-037 Parity on, same stimulus -> parity bit 0 inserted before stop; frame 44 cycles; load 0x01 -> parity bit 1.
REQ-038 Offer 0x3C while busy and toggle data_in mid-frame -> transmitted frame is unchanged, 0x3C is not sent, and load_ready stays 0 until IDLE.
REQ-039 Assert reset for 1 cycle at cycle 13 of a frame -> next cycle d_out=1, busy=0, no done pulse, and load_ready=1 the cycle after reset drops.
REQ-040 BAUD_DIV=1, back-to-back load_valid held high with 0xFF then 0x00 -> two 10-cycle frames, a single idle cycle between them, and 0xFF first.
REQ-041 Model the downstream negative-edge D flip-flop sampling d_out -> its q reproduces the d_out bit sequence, delayed by half a cycle.
